mem_wb_stage: RTL and testbench

//  Reader end of the M stage: consumes the EX/MEM bundle, runs the data-memory transaction

---
 rtl/mem_wb_stage.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Reader end of the M stage: data-memory req/gnt/rvalid transaction, load alignment/extension,
// MEM/WB pipeline register and W-stage forwarding mux.
module mem_wb_stage #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_valid,
  input  logic [31:0] M_instr,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_CAL_res,
  input  logic [31:0] M_RD2,
  input  logic [3:0]  M_mem_op,
  input  logic [2:0]  W_fwd_src_sel,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        M_stall,
  output logic        W_valid,
  output logic [31:0] W_instr,
  output logic [31:0] W_PC,
  output logic [31:0] W_CAL_res,
  output logic [31:0] W_DM_RD,
  output logic [1:0]  W_exc,
  output logic [31:0] W_fwd_src
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [1:0] EXC_NONE  = 2'd0;
  localparam logic [1:0] EXC_ALIGN = 2'd1;
  localparam logic [1:0] EXC_TMO   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;

  logic        W_valid_q;
  logic [31:0] W_instr_q, W_PC_q, W_CAL_res_q, W_DM_RD_q;
  logic [1:0]  W_exc_q;

  logic        is_load_c, is_store_c, op_word_c, op_half_c, op_byte_c, sext_c;
  logic [1:0]  off_c;
  logic        misalign_c, live_c, issue_c, tmo_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        req_c;
  logic        complete_c, resp_ok_c;
  logic [1:0]  exc_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_data_c;

  // Operation decode; unknown codes behave as "no memory op".
  always_comb begin
    is_load_c  = 1'b0;
    is_store_c = 1'b0;
    op_word_c  = 1'b0;
    op_half_c  = 1'b0;
    op_byte_c  = 1'b0;
    sext_c     = 1'b0;
    case (M_mem_op)
      OP_LW:  begin is_load_c  = 1'b1; op_word_c = 1'b1; end
      OP_LH:  begin is_load_c  = 1'b1; op_half_c = 1'b1; sext_c = 1'b1; end
      OP_LHU: begin is_load_c  = 1'b1; op_half_c = 1'b1; end
      OP_LB:  begin is_load_c  = 1'b1; op_byte_c = 1'b1; sext_c = 1'b1; end
      OP_LBU: begin is_load_c  = 1'b1; op_byte_c = 1'b1; end
      OP_SW:  begin is_store_c = 1'b1; op_word_c = 1'b1; end
      OP_SH:  begin is_store_c = 1'b1; op_half_c = 1'b1; end
      OP_SB:  begin is_store_c = 1'b1; op_byte_c = 1'b1; end
      default: ;
    endcase
  end

  assign off_c      = M_CAL_res[1:0];
  assign misalign_c = (op_word_c & (off_c != 2'b00)) | (op_half_c & off_c[0]);
  assign live_c     = M_valid & (is_load_c | is_store_c);
  assign issue_c    = live_c & ~misalign_c;
  assign tmo_c      = (cnt_q == CNT_W'(MAX_WAIT - 1));

  // Lane enables and replicated store data for the current M op.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = M_RD2;
    if (op_half_c) begin
      be_c    = 4'b0011 << off_c;
      wdata_c = {2{M_RD2[15:0]}};
    end else if (op_byte_c) begin
      be_c    = 4'b0001 << off_c;
      wdata_c = {4{M_RD2[7:0]}};
    end
  end

  // Bus fields come straight from M in IDLE, then from the captured copy while waiting for gnt.
  always_comb begin
    req_c    = 1'b0;
    dm_we    = bus_we_q;
    dm_addr  = bus_addr_q;
    dm_be    = bus_be_q;
    dm_wdata = bus_wdata_q;
    case (state_q)
      S_IDLE: begin
        req_c    = issue_c;
        dm_we    = is_store_c;
        dm_addr  = {M_CAL_res[31:2], 2'b00};
        dm_be    = be_c;
        dm_wdata = wdata_c;
      end
      S_REQ:   req_c = 1'b1;
      default: req_c = 1'b0;
    endcase
  end

  // Reset must kill the request without waiting for a clock edge.
  assign dm_req = reset & req_c;

  // Next state, completion and exception code.
  always_comb begin
    state_d    = state_q;
    complete_c = 1'b0;
    resp_ok_c  = 1'b0;
    exc_c      = EXC_NONE;
    case (state_q)
      S_IDLE: begin
        if (live_c) begin
          if (misalign_c) begin
            complete_c = 1'b1;
            exc_c      = EXC_ALIGN;
          end else if (dm_gnt) begin
            if (is_store_c) complete_c = 1'b1;
            else            state_d    = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dm_gnt) begin
          if (bus_we_q) begin
            complete_c = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end else if (tmo_c) begin
          complete_c = 1'b1;
          exc_c      = EXC_TMO;
          state_d    = S_IDLE;
        end
      end
      S_RESP: begin
        if (dm_rvalid) begin
          complete_c = 1'b1;
          resp_ok_c  = 1'b1;
          state_d    = S_IDLE;
        end else if (tmo_c) begin
          complete_c = 1'b1;
          exc_c      = EXC_TMO;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign M_stall = live_c & ~complete_c;

  // Wait counter restarts on every state change and is idle in IDLE.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if ((state_d != state_q) || (state_q == S_IDLE)) cnt_d = '0;
  end

  // Load alignment and extension.
  assign ld_byte_c = dm_rdata[{off_c, 3'b000} +: 8];
  assign ld_half_c = dm_rdata[{off_c[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_c = 32'd0;
    if (op_word_c)      ld_data_c = dm_rdata;
    else if (op_half_c) ld_data_c = {{16{sext_c & ld_half_c[15]}}, ld_half_c};
    else if (op_byte_c) ld_data_c = {{24{sext_c & ld_byte_c[7]}}, ld_byte_c};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
      W_valid_q   <= 1'b0;
      W_instr_q   <= 32'd0;
      W_PC_q      <= 32'd0;
      W_CAL_res_q <= 32'd0;
      W_DM_RD_q   <= 32'd0;
      W_exc_q     <= EXC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == S_IDLE) && issue_c) begin
        bus_we_q    <= is_store_c;
        bus_addr_q  <= {M_CAL_res[31:2], 2'b00};
        bus_be_q    <= be_c;
        bus_wdata_q <= wdata_c;
      end
      // A stalled M stage sends a bubble; everything else in W holds.
      if (M_stall) begin
        W_valid_q <= 1'b0;
      end else begin
        W_valid_q   <= M_valid;
        W_instr_q   <= M_instr;
        W_PC_q      <= M_PC;
        W_CAL_res_q <= M_CAL_res;
        W_exc_q     <= exc_c;
        W_DM_RD_q   <= (resp_ok_c && is_load_c) ? ld_data_c : 32'd0;
      end
    end
  end

  assign W_valid   = W_valid_q;
  assign W_instr   = W_instr_q;
  assign W_PC      = W_PC_q;
  assign W_CAL_res = W_CAL_res_q;
  assign W_DM_RD   = W_DM_RD_q;
  assign W_exc     = W_exc_q;

  // W-stage forwarding source.
  always_comb begin
    case (W_fwd_src_sel)
      3'd1:    W_fwd_src = W_CAL_res_q;
      3'd2:    W_fwd_src = W_DM_RD_q;
      3'd3:    W_fwd_src = W_PC_q + 32'd8;
      default: W_fwd_src = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: bus handshake, stalls, load extension, exceptions, forwarding.
module tb_mem_wb_stage;

  localparam int unsigned MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_valid;
  logic [31:0] M_instr, M_PC, M_CAL_res, M_RD2;
  logic [3:0]  M_mem_op;
  logic [2:0]  W_fwd_src_sel;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        M_stall, W_valid;
  logic [31:0] W_instr, W_PC, W_CAL_res, W_DM_RD, W_fwd_src;
  logic [1:0]  W_exc;

  int errors = 0;
  int checks = 0;

  mem_wb_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .M_valid(M_valid), .M_instr(M_instr), .M_PC(M_PC), .M_CAL_res(M_CAL_res),
    .M_RD2(M_RD2), .M_mem_op(M_mem_op), .W_fwd_src_sel(W_fwd_src_sel),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .M_stall(M_stall), .W_valid(W_valid), .W_instr(W_instr), .W_PC(W_PC),
    .W_CAL_res(W_CAL_res), .W_DM_RD(W_DM_RD), .W_exc(W_exc), .W_fwd_src(W_fwd_src)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] cal,
                         input logic [31:0] rd2, input logic [3:0] op);
    M_valid   = 1'b1;
    M_instr   = instr;
    M_PC      = pc;
    M_CAL_res = cal;
    M_RD2     = rd2;
    M_mem_op  = op;
  endtask

  task automatic idle_m();
    M_valid   = 1'b0;
    M_mem_op  = 4'd0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
  endtask

  // Load granted at once, data one cycle later; W holds the result on return.
  task automatic run_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rdata);
    drive_m(32'h0000_0003, 32'h0000_0100, addr, 32'd0, op);
    dm_gnt = 1'b1;
    tick();
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b1;
    dm_rdata  = rdata;
    tick();
    idle_m();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_m();
    M_instr = 32'd0; M_PC = 32'd0; M_CAL_res = 32'd0; M_RD2 = 32'd0; dm_rdata = 32'd0;
    W_fwd_src_sel = 3'd3;
    repeat (2) @(posedge clk);
    #1;
    drive_m(32'h0000_0003, 32'h0000_0040, 32'h0000_0010, 32'd0, 4'd1);
    #1;
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", dm_req); end
    checks++; if (W_valid !== 1'b0) begin errors++; $display("FAIL rst_wvalid: got %b want 0", W_valid); end
    checks++; if (W_PC !== 32'd0) begin errors++; $display("FAIL rst_wpc: got %h want 0", W_PC); end
    checks++; if (W_DM_RD !== 32'd0) begin errors++; $display("FAIL rst_dmrd: got %h want 0", W_DM_RD); end
    checks++; if (W_exc !== 2'd0) begin errors++; $display("FAIL rst_exc: got %0d want 0", W_exc); end
    checks++; if (W_fwd_src !== 32'h8) begin errors++; $display("FAIL rst_fwd_pc8: got %h want 8", W_fwd_src); end
    idle_m();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    drive_m(32'h0000_2003, 32'h0000_1000, 32'h0000_0010, 32'd0, 4'd1);
    dm_gnt    = 1'b1;
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h1111_1111;
    #1;
    checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL lw_req: got %b want 1", dm_req); end
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL lw_we: got %b want 0", dm_we); end
    checks++; if (dm_addr !== 32'h10) begin errors++; $display("FAIL lw_addr: got %h want 10", dm_addr); end
    checks++; if (dm_be !== 4'hF) begin errors++; $display("FAIL lw_be: got %b want 1111", dm_be); end
    checks++; if (M_stall !== 1'b1) begin errors++; $display("FAIL lw_stall_gnt: got %b want 1", M_stall); end
    tick();
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b1;
    dm_rdata  = 32'hDEAD_BEEF;
    #1;
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL lw_req_resp: got %b want 0", dm_req); end
    checks++; if (M_stall !== 1'b0) begin errors++; $display("FAIL lw_stall_rv: got %b want 0", M_stall); end
    tick();
    idle_m();
    W_fwd_src_sel = 3'd2;
    #1;
    checks++; if (W_valid !== 1'b1) begin errors++; $display("FAIL lw_wvalid: got %b want 1", W_valid); end
    checks++; if (W_PC !== 32'h1000) begin errors++; $display("FAIL lw_wpc: got %h want 1000", W_PC); end
    checks++; if (W_DM_RD !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_dmrd: got %h want deadbeef", W_DM_RD); end
    checks++; if (W_fwd_src !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_fwd: got %h want deadbeef", W_fwd_src); end
    checks++; if (W_exc !== 2'd0) begin errors++; $display("FAIL lw_exc: got %0d want 0", W_exc); end
  endtask

  task automatic test_load_ext();
    run_load(4'd4, 32'h13, 32'h80FF_FFFF);
    checks++; if (W_DM_RD !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb13: got %h want ffffff80", W_DM_RD); end
    run_load(4'd5, 32'h13, 32'h80FF_FFFF);
    checks++; if (W_DM_RD !== 32'h0000_0080) begin errors++; $display("FAIL lbu13: got %h want 00000080", W_DM_RD); end
    run_load(4'd2, 32'h12, 32'h8001_1234);
    checks++; if (W_DM_RD !== 32'hFFFF_8001) begin errors++; $display("FAIL lh12: got %h want ffff8001", W_DM_RD); end
    run_load(4'd3, 32'h10, 32'h8001_F234);
    checks++; if (W_DM_RD !== 32'h0000_F234) begin errors++; $display("FAIL lhu10: got %h want 0000f234", W_DM_RD); end
    run_load(4'd4, 32'h11, 32'h0000_7F00);
    checks++; if (W_DM_RD !== 32'h0000_007F) begin errors++; $display("FAIL lb11: got %h want 0000007f", W_DM_RD); end
  endtask

  task automatic test_store_wait();
    int stalls;
    stalls = 0;
    drive_m(32'h0000_1023, 32'h0000_0200, 32'h0000_0012, 32'h1234_ABCD, 4'd7);
    for (int i = 0; i < 4; i++) begin
      dm_gnt = (i == 3);
      #1;
      checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL sh_req[%0d]: got %b want 1", i, dm_req); end
      checks++; if (dm_we !== 1'b1) begin errors++; $display("FAIL sh_we[%0d]: got %b want 1", i, dm_we); end
      checks++; if (dm_addr !== 32'h10) begin errors++; $display("FAIL sh_addr[%0d]: got %h want 10", i, dm_addr); end
      checks++; if (dm_be !== 4'b1100) begin errors++; $display("FAIL sh_be[%0d]: got %b want 1100", i, dm_be); end
      checks++; if (dm_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata[%0d]: got %h want abcdabcd", i, dm_wdata); end
      if (i == 1) begin
        checks++; if (W_valid !== 1'b0) begin errors++; $display("FAIL sh_bubble: got %b want 0", W_valid); end
      end
      if (M_stall) stalls++;
      tick();
    end
    idle_m();
    #1;
    checks++; if (stalls !== 3) begin errors++; $display("FAIL sh_stalls: got %0d want 3", stalls); end
    checks++; if (W_valid !== 1'b1) begin errors++; $display("FAIL sh_wvalid: got %b want 1", W_valid); end
    checks++; if (W_PC !== 32'h200) begin errors++; $display("FAIL sh_wpc: got %h want 200", W_PC); end
    checks++; if (W_DM_RD !== 32'd0) begin errors++; $display("FAIL sh_dmrd: got %h want 0", W_DM_RD); end
    drive_m(32'h0000_0023, 32'h0000_0204, 32'h0000_0011, 32'h0000_005A, 4'd8);
    dm_gnt = 1'b1;
    #1;
    checks++; if (dm_be !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b want 0010", dm_be); end
    checks++; if (dm_wdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL sb_wdata: got %h want 5a5a5a5a", dm_wdata); end
    checks++; if (M_stall !== 1'b0) begin errors++; $display("FAIL sb_stall: got %b want 0", M_stall); end
    tick();
    idle_m();
    #1;
  endtask

  task automatic test_misalign();
    drive_m(32'h0000_2003, 32'h0000_0300, 32'h0000_0011, 32'd0, 4'd1);
    dm_gnt = 1'b1;
    #1;
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b want 0", dm_req); end
    checks++; if (M_stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b want 0", M_stall); end
    tick();
    idle_m();
    #1;
    checks++; if (W_exc !== 2'd1) begin errors++; $display("FAIL mis_lw_exc: got %0d want 1", W_exc); end
    checks++; if (W_valid !== 1'b1) begin errors++; $display("FAIL mis_wvalid: got %b want 1", W_valid); end
    drive_m(32'h0000_1023, 32'h0000_0304, 32'h0000_0013, 32'd0, 4'd7);
    tick();
    idle_m();
    #1;
    checks++; if (W_exc !== 2'd1) begin errors++; $display("FAIL mis_sh_exc: got %0d want 1", W_exc); end
  endtask

  task automatic test_timeout();
    int stalls;
    stalls = 0;
    drive_m(32'h0000_2003, 32'h0000_0400, 32'h0000_0020, 32'd0, 4'd1);
    dm_gnt = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!M_stall) break;
      stalls++;
      tick();
      dm_gnt = 1'b0;
    end
    checks++; if (stalls !== MAX_WAIT) begin errors++; $display("FAIL tmo_ld_stalls: got %0d want %0d", stalls, MAX_WAIT); end
    tick();
    idle_m();
    #1;
    checks++; if (W_exc !== 2'd2) begin errors++; $display("FAIL tmo_ld_exc: got %0d want 2", W_exc); end
    checks++; if (W_DM_RD !== 32'd0) begin errors++; $display("FAIL tmo_ld_dmrd: got %h want 0", W_DM_RD); end
    checks++; if (W_valid !== 1'b1) begin errors++; $display("FAIL tmo_ld_wvalid: got %b want 1", W_valid); end
    stalls = 0;
    drive_m(32'h0000_2023, 32'h0000_0500, 32'h0000_0024, 32'h7777_7777, 4'd6);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!M_stall) break;
      stalls++;
      tick();
    end
    checks++; if (stalls !== MAX_WAIT) begin errors++; $display("FAIL tmo_st_stalls: got %0d want %0d", stalls, MAX_WAIT); end
    tick();
    idle_m();
    #1;
    checks++; if (W_exc !== 2'd2) begin errors++; $display("FAIL tmo_st_exc: got %0d want 2", W_exc); end
    checks++; if (W_PC !== 32'h500) begin errors++; $display("FAIL tmo_st_wpc: got %h want 500", W_PC); end
  endtask

  task automatic test_reset_mid();
    drive_m(32'h0000_2003, 32'h0000_0600, 32'h0000_0030, 32'd0, 4'd1);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", dm_req); end
    checks++; if (W_valid !== 1'b0) begin errors++; $display("FAIL rmid_wvalid: got %b want 0", W_valid); end
    checks++; if (W_PC !== 32'd0) begin errors++; $display("FAIL rmid_wpc: got %h want 0", W_PC); end
    checks++; if (W_CAL_res !== 32'd0) begin errors++; $display("FAIL rmid_wcal: got %h want 0", W_CAL_res); end
    checks++; if (W_exc !== 2'd0) begin errors++; $display("FAIL rmid_exc: got %0d want 0", W_exc); end
    idle_m();
    tick();
    reset = 1'b1;
    tick();
    dm_rvalid = 1'b1;
    dm_rdata  = 32'hCAFE_F00D;
    tick();
    dm_rvalid = 1'b0;
    #1;
    checks++; if (W_DM_RD !== 32'd0) begin errors++; $display("FAIL late_rv_dmrd: got %h want 0", W_DM_RD); end
    checks++; if (W_valid !== 1'b0) begin errors++; $display("FAIL late_rv_wvalid: got %b want 0", W_valid); end
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL late_rv_req: got %b want 0", dm_req); end
    run_load(4'd1, 32'h40, 32'h0BAD_F00D);
    checks++; if (W_DM_RD !== 32'h0BAD_F00D) begin errors++; $display("FAIL post_rst_lw: got %h want 0badf00d", W_DM_RD); end
  endtask

  task automatic test_fwd_pc8();
    drive_m(32'h0000_006F, 32'h0000_3000, 32'h0000_3004, 32'd0, 4'd0);
    W_fwd_src_sel = 3'd3;
    #1;
    checks++; if (M_stall !== 1'b0) begin errors++; $display("FAIL jal_stall: got %b want 0", M_stall); end
    tick();
    idle_m();
    #1;
    checks++; if (W_fwd_src !== 32'h3008) begin errors++; $display("FAIL fwd_pc8: got %h want 3008", W_fwd_src); end
    W_fwd_src_sel = 3'd1;
    #1;
    checks++; if (W_fwd_src !== 32'h3004) begin errors++; $display("FAIL fwd_cal: got %h want 3004", W_fwd_src); end
    W_fwd_src_sel = 3'd2;
    #1;
    checks++; if (W_fwd_src !== 32'd0) begin errors++; $display("FAIL fwd_dmrd_nonload: got %h want 0", W_fwd_src); end
    W_fwd_src_sel = 3'd5;
    #1;
    checks++; if (W_fwd_src !== 32'd0) begin errors++; $display("FAIL fwd_other: got %h want 0", W_fwd_src); end
    drive_m(32'h0000_006F, 32'hFFFF_FFFC, 32'd0, 32'd0, 4'd0);
    W_fwd_src_sel = 3'd3;
    tick();
    idle_m();
    #1;
    checks++; if (W_fwd_src !== 32'h0000_0004) begin errors++; $display("FAIL fwd_pc8_wrap: got %h want 00000004", W_fwd_src); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store_wait();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_fwd_pc8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
